// File: rtl/agc_rms_sched.sv
// AGC RMS sequencer: pulses the mux LFSR sync, waits out the mux pipeline, then accumulates
// sum and sum-of-squares of |sample| for a latched number of clocks and holds the result until ack.
module agc_rms_sched #(
    parameter int CNT_W      = 24,
    parameter int IN_LATENCY = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               cont_i,
    input  logic [CNT_W-1:0]   period_i,
    input  logic [3:0]         samp_i,
    output logic               sync_o,
    output logic               lfsr_rst_o,
    output logic               busy_o,
    output logic               valid_o,
    input  logic               ack_i,
    output logic [CNT_W+3:0]   sum_o,
    output logic [CNT_W+7:0]   sqsum_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // SYNC  | one-cycle sync pulse to the mux, accumulators cleared
    // FLUSH | IN_LATENCY cycles of mux pipeline, samples discarded
    // ACCUM | latched-period cycles of accumulation
    // DONE  | result presented, waiting for ack_i
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_FLUSH,
        S_ACCUM,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(IN_LATENCY - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W+3:0]   acc_sum_q, acc_sum_d;
    logic [CNT_W+7:0]   acc_sq_q, acc_sq_d;
    logic [CNT_W+3:0]   sum_q, sum_d;
    logic [CNT_W+7:0]   sq_q, sq_d;
    logic               lfsr_rst_q;

    logic [7:0]         samp_sq;
    logic [CNT_W+3:0]   samp_ext;
    logic [CNT_W+7:0]   samp_sq_ext;

    assign samp_sq     = {4'b0000, samp_i} * {4'b0000, samp_i};
    assign samp_ext    = {{CNT_W{1'b0}}, samp_i};
    assign samp_sq_ext = {{CNT_W{1'b0}}, samp_sq};

    always_ff @(posedge clk_i) begin
        lfsr_rst_q <= ~rst_n_i;
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            acc_sum_q <= '0;
            acc_sq_q  <= '0;
            sum_q     <= '0;
            sq_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            acc_sum_q <= acc_sum_d;
            acc_sq_q  <= acc_sq_d;
            sum_q     <= sum_d;
            sq_q      <= sq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        acc_sum_d = acc_sum_q;
        acc_sq_d  = acc_sq_q;
        sum_d     = sum_q;
        sq_d      = sq_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i && (period_i != '0)) begin
                    state_d  = S_SYNC;
                    period_d = period_i;
                end
            end
            S_SYNC: begin
                acc_sum_d = '0;
                acc_sq_d  = '0;
                cnt_d     = FLUSH_LD;
                state_d   = stop_i ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_ACCUM;
                    cnt_d   = period_q - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_ACCUM: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_sum_d = acc_sum_q + samp_ext;
                    acc_sq_d  = acc_sq_q + samp_sq_ext;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        sum_d   = acc_sum_d;
                        sq_d    = acc_sq_d;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            S_DONE: begin
                if (ack_i) begin
                    if (cont_i && (period_i != '0)) begin
                        state_d  = S_SYNC;
                        period_d = period_i;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sync_o     = (state_q == S_SYNC);
    assign busy_o     = (state_q == S_SYNC) || (state_q == S_FLUSH) || (state_q == S_ACCUM);
    assign valid_o    = (state_q == S_DONE);
    assign lfsr_rst_o = lfsr_rst_q;
    assign sum_o      = sum_q;
    assign sqsum_o    = sq_q;

endmodule
